// File: rtl/serial_add_if.sv
// Handshake and full-adder bus between the serial add sequencer and its surroundings.
// The slave side is the sequencer; the master side holds the requester and the external adder.
interface serial_add_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             fa_a;
    logic             fa_b;
    logic             fa_cin;
    logic             fa_y;
    logic             fa_cout;

    modport master (
        output start, a, b, fa_y, fa_cout,
        input  busy, done, sum, cout, fa_a, fa_b, fa_cin
    );

    modport slave (
        input  start, a, b, fa_y, fa_cout,
        output busy, done, sum, cout, fa_a, fa_b, fa_cin
    );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: steps one external full adder through WIDTH cycles,
// LSB first, recirculating the carry through a register.
module serial_add_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    serial_add_if.slave  bus
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] s_sh;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            s_sh   <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            sum_r  <= '0;
            cout_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_sh   <= bus.a;
                        b_sh   <= bus.b;
                        carry  <= 1'b0;
                        cnt    <= '0;
                        busy_r <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    s_sh  <= {bus.fa_y, s_sh[WIDTH-1:1]};
                    carry <= bus.fa_cout;
                    a_sh  <= {1'b0, a_sh[WIDTH-1:1]};
                    b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
                    cnt   <= cnt + CNT_W'(1);
                    if (cnt == LAST) begin
                        sum_r  <= {bus.fa_y, s_sh[WIDTH-1:1]};
                        cout_r <= bus.fa_cout;
                        cnt    <= '0;
                        done_r <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    done_r <= 1'b0;
                    // A start still held here chains straight into the next add,
                    // keeping throughput at one result per WIDTH+1 cycles.
                    if (bus.start) begin
                        a_sh  <= bus.a;
                        b_sh  <= bus.b;
                        carry <= 1'b0;
                        cnt   <= '0;
                        state <= RUN;
                    end else begin
                        busy_r <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: begin
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    // Adder drive is gated by state so the adder sees zeros outside RUN.
    assign bus.fa_a   = (state == RUN) & a_sh[0];
    assign bus.fa_b   = (state == RUN) & b_sh[0];
    assign bus.fa_cin = (state == RUN) & carry;

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.sum  = sum_r;
    assign bus.cout = cout_r;
endmodule
